signal_capture_v1_0: RTL and testbench
======================================

# signal_capture_v1_0

Single-shot triggered capture buffer for signed 16-bit sample streams; it is the write-side counterpart of the playback generator. On each clock-enable tick it writes the incoming sample into a 2^DEPTH_LOG2-entry circular memory and detects a level-crossing trigger. After the trigger it keeps writing to complete a window that holds PRETRIG pre-trigger samples, then freezes. The frozen window is read back through a registered, trigger-relative read port for host or debug logic.

## Interface
- DEPTH_LOG2, 7, log2 of buffer depth (DEPTH = 128).
- PRETRIG, 16, number of samples kept before the trigger sample; range 0..DEPTH-1.
- AUTOTRIG_TIMEOUT, 4096, cen ticks in WAIT_TRIG before a forced trigger (only with CAPTURE_AUTOTRIG_EN).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- cen  in  1  sample strobe; one sample per high cycle.
- is16_signal  in  16  signed input sample.
- i_arm  in  1  single-cycle pulse; starts or restarts a capture.
- is16_trig_level  in  16  signed trigger threshold.
- i_trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
- i_rd_addr  in  DEPTH_LOG2  window-relative read address; 0 = oldest sample.
- ors16_rd_data  out  16  signed read data.
- o_armed  out  1  high in PREFILL, WAIT_TRIG and POST.
- o_triggered  out  1  high from trigger acceptance until the next arm.
- o_done  out  1  high in DONE; window valid.
- o_autotrig  out  1  high when the trigger was forced by timeout.

## Operation
- Reset: all outputs 0, state IDLE, wr_ptr = 0, start_ptr = 0, counters 0, prev-sample valid flag cleared. Memory contents are not reset.
- States:
  - IDLE: cen ignored.
  - PREFILL: writes samples until PRETRIG samples have been written since arm.
  - WAIT_TRIG: keeps writing circularly and evaluates the trigger.
  - POST: writes DEPTH-PRETRIG-1 samples after the trigger sample.
  - DONE: no writes; holds until i_arm.
- i_arm from any state:
  - wr_ptr <= 0; counters, prev-valid and all status flags cleared; next state PREFILL.
  - If PRETRIG = 0, next state is WAIT_TRIG.
- Write on cen in PREFILL/WAIT_TRIG/POST: mem[wr_ptr] <= is16_signal; wr_ptr increments mod DEPTH; prev <= is16_signal; prev-valid <= 1.
- Trigger condition, evaluated only in WAIT_TRIG on a cen tick with prev-valid set:
  - Rising: prev < level and cur >= level.
  - Falling: prev > level and cur <= level.
  - Comparisons are signed 16-bit.
  - Crossings during PREFILL are ignored, but prev is still tracked.
- On trigger:
  - The current sample is written at wr_ptr as normal.
  - start_ptr <= (wr_ptr - PRETRIG) mod DEPTH.
  - o_triggered <= 1; state POST; post counter loaded with DEPTH-PRETRIG-1.
- POST: each cen writes one sample and decrements the counter. The write that takes the counter to 0 moves the state to DONE and sets o_done.
- If DEPTH-PRETRIG-1 = 0, the trigger cycle itself goes straight to DONE.
- Read path: ors16_rd_data <= mem[(start_ptr + i_rd_addr) mod DEPTH] every cycle in every state. Data is meaningful only while o_done = 1.

## Timing
- i_arm at edge N: state is PREFILL after N; the first captured sample is the first cen at edge N+1 or later.
- i_arm and cen in the same cycle: arm wins and the sample is discarded.
- Trigger sample on cen at edge T: o_triggered = 1 after T.
- Last post sample at edge D: o_done = 1 after D; o_armed = 0 after D.
- Read latency is 1 cycle: an address presented before edge R appears on ors16_rd_data after R.
- Window layout: rd_addr PRETRIG = trigger sample; rd_addr DEPTH-1 = last post sample.
- rstn low has priority over i_arm and cen at every edge; a reset mid-capture returns to IDLE.

## Configuration
- CAPTURE_AUTOTRIG_EN defined:
  - In WAIT_TRIG, a counter counts cen ticks and is cleared on arm and on entry to WAIT_TRIG.
  - On the tick where it reaches AUTOTRIG_TIMEOUT with no real trigger, the current sample is treated as the trigger and o_autotrig <= 1 together with o_triggered.
  - A real trigger on the same tick takes precedence and o_autotrig stays 0.
- CAPTURE_AUTOTRIG_EN undefined: no timeout logic; WAIT_TRIG persists indefinitely; o_autotrig tied to 0.

## Test plan
All scenarios use DEPTH_LOG2 = 7 and PRETRIG = 16, with sample n = n-th cen tick after arm (n from 0).
1. Reset with cen toggling and is16_signal = 100 -> all outputs 0; no state change without i_arm.
2. Arm; ramp cur = 8n; level 800; rising -> trigger at n = 100; o_done after sample 211; then rd_addr 0 -> 672, rd_addr 16 -> 800, rd_addr 127 -> 1688.
3. Arm; ramp 8n; level 40 (crossing at n = 5, inside PREFILL); no macro -> o_triggered stays 0 through n = 10000.
4. Arm; cur = 1000 - 10n; level 500; falling -> trigger at n = 50; rd_addr 16 -> 500; rd_addr 0 -> 660.
5. Arm, trigger, then i_arm again 20 cen ticks into POST -> o_triggered = 0, o_done = 0 next cycle; a new capture completes correctly; i_arm and cen in the same cycle drops that sample.
6. With CAPTURE_AUTOTRIG_EN: constant input 0 -> o_triggered = o_autotrig = 1 on the 4096th WAIT_TRIG tick; o_done 111 ticks later. Without the macro: both stay 0.

Source files
------------

// File: rtl/signal_capture_v1_0.sv
// Single-shot triggered capture buffer for signed 16-bit samples with a frozen, trigger-relative read window.
// Optional timeout trigger is compiled in with CAPTURE_AUTOTRIG_EN.
module signal_capture_v1_0 #(
    parameter int DEPTH_LOG2       = 7,
    parameter int PRETRIG          = 16,
    parameter int AUTOTRIG_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cen,
    input  logic signed [15:0]      is16_signal,
    input  logic                    i_arm,
    input  logic signed [15:0]      is16_trig_level,
    input  logic                    i_trig_rising,
    input  logic [DEPTH_LOG2-1:0]   i_rd_addr,
    output logic signed [15:0]      ors16_rd_data,
    output logic                    o_armed,
    output logic                    o_triggered,
    output logic                    o_done,
    output logic                    o_autotrig
);

    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int POST_LEN = DEPTH - PRETRIG - 1;
    localparam logic [DEPTH_LOG2-1:0] PRETRIG_W  = DEPTH_LOG2'(PRETRIG);
    localparam logic [DEPTH_LOG2-1:0] POST_LEN_W = DEPTH_LOG2'(POST_LEN);
    localparam logic [DEPTH_LOG2-1:0] ONE_W      = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] ZERO_W     = DEPTH_LOG2'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_WAIT    = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    logic signed [15:0]      mem_r [DEPTH];
    state_t                  state_r, state_n;
    logic [DEPTH_LOG2-1:0]   wr_ptr_r, wr_ptr_n;
    logic [DEPTH_LOG2-1:0]   start_ptr_r, start_ptr_n;
    logic [DEPTH_LOG2-1:0]   cnt_r, cnt_n;
    logic signed [15:0]      prev_r, prev_n;
    logic                    prev_valid_r, prev_valid_n;
    logic                    triggered_r, triggered_n;
    logic                    autotrig_r, autotrig_n;
    logic                    armed_r, armed_n;
    logic                    done_r, done_n;
    logic signed [15:0]      rd_data_r;
    logic [DEPTH_LOG2-1:0]   rd_idx_s;
    logic                    wr_en_s;
    logic                    writing_s;
    logic                    real_trig_s;
    logic                    force_trig_s;
    logic                    rise_s;
    logic                    fall_s;

`ifdef CAPTURE_AUTOTRIG_EN
    localparam int AT_W = $clog2(AUTOTRIG_TIMEOUT + 1);
    logic [AT_W-1:0] at_cnt_r, at_cnt_n;
    logic [AT_W-1:0] at_inc_s;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(AUTOTRIG_TIMEOUT);
`endif

    // Next-state, pointer, counter and status logic
    always_comb begin
        state_n      = state_r;
        wr_ptr_n     = wr_ptr_r;
        start_ptr_n  = start_ptr_r;
        cnt_n        = cnt_r;
        prev_n       = prev_r;
        prev_valid_n = prev_valid_r;
        triggered_n  = triggered_r;
        autotrig_n   = autotrig_r;
        wr_en_s      = 1'b0;
        real_trig_s  = 1'b0;
        force_trig_s = 1'b0;
        rd_idx_s     = start_ptr_r + i_rd_addr;
        rise_s       = (prev_r < is16_trig_level) && (is16_signal >= is16_trig_level);
        fall_s       = (prev_r > is16_trig_level) && (is16_signal <= is16_trig_level);
        writing_s    = (state_r == ST_PREFILL) || (state_r == ST_WAIT) || (state_r == ST_POST);
`ifdef CAPTURE_AUTOTRIG_EN
        at_cnt_n     = at_cnt_r;
        at_inc_s     = at_cnt_r + AT_W'(1);
`endif

        if (i_arm) begin
            // Arm wins over a coincident sample; that sample is dropped
            wr_ptr_n     = ZERO_W;
            cnt_n        = ZERO_W;
            prev_valid_n = 1'b0;
            triggered_n  = 1'b0;
            autotrig_n   = 1'b0;
            state_n      = (PRETRIG == 0) ? ST_WAIT : ST_PREFILL;
`ifdef CAPTURE_AUTOTRIG_EN
            at_cnt_n     = AT_W'(0);
`endif
        end else if (cen && writing_s) begin
            wr_en_s      = 1'b1;
            wr_ptr_n     = wr_ptr_r + ONE_W;
            prev_n       = is16_signal;
            prev_valid_n = 1'b1;
            case (state_r)
                ST_PREFILL: begin
                    if (cnt_r == PRETRIG_W - ONE_W) begin
                        cnt_n   = ZERO_W;
                        state_n = ST_WAIT;
`ifdef CAPTURE_AUTOTRIG_EN
                        at_cnt_n = AT_W'(0);
`endif
                    end else begin
                        cnt_n = cnt_r + ONE_W;
                    end
                end
                ST_WAIT: begin
                    real_trig_s = prev_valid_r && (i_trig_rising ? rise_s : fall_s);
`ifdef CAPTURE_AUTOTRIG_EN
                    at_cnt_n     = at_inc_s;
                    force_trig_s = !real_trig_s && (at_inc_s == AT_W'(AUTOTRIG_TIMEOUT));
`endif
                    if (real_trig_s || force_trig_s) begin
                        start_ptr_n = wr_ptr_r - PRETRIG_W;
                        triggered_n = 1'b1;
                        autotrig_n  = force_trig_s;
                        cnt_n       = POST_LEN_W;
                        state_n     = (POST_LEN == 0) ? ST_DONE : ST_POST;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
                ST_POST: begin
                    cnt_n = cnt_r - ONE_W;
                    if (cnt_r == ONE_W) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_POST;
                    end
                end
                default: begin
                    state_n = state_r;
                end
            endcase
        end else begin
            state_n = state_r;
        end

        armed_n = (state_n == ST_PREFILL) || (state_n == ST_WAIT) || (state_n == ST_POST);
        done_n  = (state_n == ST_DONE);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= ZERO_W;
            start_ptr_r  <= ZERO_W;
            cnt_r        <= ZERO_W;
            prev_r       <= 16'sd0;
            prev_valid_r <= 1'b0;
            triggered_r  <= 1'b0;
            autotrig_r   <= 1'b0;
            armed_r      <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            wr_ptr_r     <= wr_ptr_n;
            start_ptr_r  <= start_ptr_n;
            cnt_r        <= cnt_n;
            prev_r       <= prev_n;
            prev_valid_r <= prev_valid_n;
            triggered_r  <= triggered_n;
            autotrig_r   <= autotrig_n;
            armed_r      <= armed_n;
            done_r       <= done_n;
        end
    end

`ifdef CAPTURE_AUTOTRIG_EN
    // Timeout counter for the forced trigger
    always_ff @(posedge clk) begin
        if (!rstn) begin
            at_cnt_r <= AT_W'(0);
        end else begin
            at_cnt_r <= at_cnt_n;
        end
    end
`endif

    // Sample memory write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (rstn && wr_en_s) begin
            mem_r[wr_ptr_r] <= is16_signal;
        end
    end

    // Registered trigger-relative read port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_r <= 16'sd0;
        end else begin
            rd_data_r <= mem_r[rd_idx_s];
        end
    end

    assign ors16_rd_data = rd_data_r;
    assign o_armed       = armed_r;
    assign o_triggered   = triggered_r;
    assign o_done        = done_r;
    assign o_autotrig    = autotrig_r;

endmodule

// File: tb/tb_signal_capture_v1_0.sv
// Self-checking bench for signal_capture_v1_0: read-back tables, scoreboard queue, multi-cycle sequences.
`timescale 1ns/1ps
module tb_signal_capture_v1_0;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cen = 1'b0;
    logic signed [15:0] is16_signal = 16'sd0;
    logic               i_arm = 1'b0;
    logic signed [15:0] is16_trig_level = 16'sd0;
    logic               i_trig_rising = 1'b1;
    logic [6:0]         i_rd_addr = 7'd0;
    logic signed [15:0] ors16_rd_data;
    logic               o_armed, o_triggered, o_done, o_autotrig;

    signal_capture_v1_0 #(.DEPTH_LOG2(7), .PRETRIG(16), .AUTOTRIG_TIMEOUT(4096)) dut (
        .clk(clk), .rstn(rstn), .cen(cen), .is16_signal(is16_signal), .i_arm(i_arm),
        .is16_trig_level(is16_trig_level), .i_trig_rising(i_trig_rising), .i_rd_addr(i_rd_addr),
        .ors16_rd_data(ors16_rd_data), .o_armed(o_armed), .o_triggered(o_triggered),
        .o_done(o_done), .o_autotrig(o_autotrig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        int         exp;
    } rd_vec_t;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int trig_n, done_n, auto_seen;
    int exp_trig, exp_done, exp_auto;
    rd_vec_t tv_ramp[6];
    rd_vec_t tv_fall[3];
    rd_vec_t tv_drop[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: saturating ramp 8n; 1: 1000-10n; 3: prefill-crossing probe; other: constant 0
    function automatic int sample(input int mode, input int n);
        int v;
        case (mode)
            0: v = (8 * n > 32767) ? 32767 : 8 * n;
            1: v = 1000 - 10 * n;
            3: v = (n == 15) ? 0 : (n == 30) ? 400 : (n > 30) ? n : 1000;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic arm(input logic with_cen);
        i_arm = 1'b1;
        cen = with_cen;
        is16_signal = 16'sd12345;
        tick();
        i_arm = 1'b0;
        cen = 1'b0;
        check("arm_armed", int'(o_armed), 1);
        check("arm_triggered", int'(o_triggered), 0);
        check("arm_done", int'(o_done), 0);
    endtask

    task automatic stream(input int mode, input int max_n, output int t_n, output int d_n, output int a_seen);
        t_n = -1;
        d_n = -1;
        a_seen = 0;
        for (int n = 0; n < max_n; n++) begin
            cen = 1'b1;
            is16_signal = 16'(sample(mode, n));
            tick();
            if (t_n < 0 && o_triggered) t_n = n;
            if (o_autotrig) a_seen = 1;
            if (o_done) begin
                d_n = n;
                break;
            end
        end
        cen = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [6:0] a, input int e);
        i_rd_addr = a;
        exp_q.push_back(e);
        tick();
        check(name, int'(ors16_rd_data), exp_q.pop_front());
    endtask

    initial begin
        tv_ramp[0] = '{7'd0,   672};
        tv_ramp[1] = '{7'd16,  800};
        tv_ramp[2] = '{7'd127, 1688};
        tv_ramp[3] = '{7'd1,   680};
        tv_ramp[4] = '{7'd15,  792};
        tv_ramp[5] = '{7'd17,  808};
        tv_fall[0] = '{7'd16,  500};
        tv_fall[1] = '{7'd0,   660};
        tv_fall[2] = '{7'd127, -610};
        tv_drop[0] = '{7'd0,   1000};
        tv_drop[1] = '{7'd1,   0};
        tv_drop[2] = '{7'd15,  1000};
        tv_drop[3] = '{7'd16,  400};
        tv_drop[4] = '{7'd127, 141};

        // Reset with cen toggling, then idle without arm
        rstn = 1'b0;
        is16_signal = 16'sd100;
        for (int i = 0; i < 6; i++) begin
            cen = (i % 2 == 0);
            tick();
        end
        check("rst_armed", int'(o_armed), 0);
        check("rst_triggered", int'(o_triggered), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_autotrig", int'(o_autotrig), 0);
        check("rst_rd_data", int'(ors16_rd_data), 0);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cen = (i % 2 == 0);
            tick();
        end
        cen = 1'b0;
        check("idle_armed", int'(o_armed), 0);
        check("idle_done", int'(o_done), 0);

        // Rising ramp capture
        is16_trig_level = 16'sd800;
        i_trig_rising = 1'b1;
        arm(1'b0);
        stream(0, 300, trig_n, done_n, auto_seen);
        check("ramp_trig_n", trig_n, 100);
        check("ramp_done_n", done_n, 211);
        check("ramp_armed_after_done", int'(o_armed), 0);
        check("ramp_autotrig", auto_seen, 0);
        cen = 1'b1;
        is16_signal = -16'sd1;
        for (int i = 0; i < 5; i++) tick();
        cen = 1'b0;
        check("ramp_done_hold", int'(o_done), 1);
        foreach (tv_ramp[i]) rd_check("ramp_rd", tv_ramp[i].addr, tv_ramp[i].exp);
        for (int a = 40; a < 128; a += 29) rd_check("ramp_rd_model", 7'(a), sample(0, 84 + a));

        // Crossing inside prefill must not trigger
        is16_trig_level = 16'sd40;
        arm(1'b0);
        stream(0, 10001, trig_n, done_n, auto_seen);
`ifdef CAPTURE_AUTOTRIG_EN
        exp_trig = 4111; exp_done = 4222;
`else
        exp_trig = -1;   exp_done = -1;
`endif
        check("prefill_cross_trig_n", trig_n, exp_trig);
        check("prefill_cross_done_n", done_n, exp_done);

        // Falling ramp capture
        is16_trig_level = 16'sd500;
        i_trig_rising = 1'b0;
        arm(1'b0);
        stream(1, 300, trig_n, done_n, auto_seen);
        check("fall_trig_n", trig_n, 50);
        check("fall_done_n", done_n, 161);
        foreach (tv_fall[i]) rd_check("fall_rd", tv_fall[i].addr, tv_fall[i].exp);

        // Re-arm 20 ticks into POST, then arm coincident with cen
        is16_trig_level = 16'sd800;
        i_trig_rising = 1'b1;
        arm(1'b0);
        stream(0, 121, trig_n, done_n, auto_seen);
        check("rearm_trig_n", trig_n, 100);
        check("rearm_not_done", done_n, -1);
        arm(1'b0);
        arm(1'b1);
        is16_trig_level = 16'sd500;
        i_trig_rising = 1'b0;
        stream(3, 300, trig_n, done_n, auto_seen);
        check("drop_trig_n", trig_n, 30);
        check("drop_done_n", done_n, 141);
        foreach (tv_drop[i]) rd_check("drop_rd", tv_drop[i].addr, tv_drop[i].exp);

        // Constant input: only the timeout can trigger
        is16_trig_level = 16'sd100;
        i_trig_rising = 1'b1;
        arm(1'b0);
        stream(2, 5000, trig_n, done_n, auto_seen);
`ifdef CAPTURE_AUTOTRIG_EN
        exp_trig = 4111; exp_done = 4222; exp_auto = 1;
`else
        exp_trig = -1;   exp_done = -1;   exp_auto = 0;
`endif
        check("auto_trig_n", trig_n, exp_trig);
        check("auto_done_n", done_n, exp_done);
        check("auto_flag", auto_seen, exp_auto);
        check("auto_flag_now", int'(o_autotrig), exp_auto);

        // Reset mid-capture beats a coincident arm and sample
        arm(1'b0);
        stream(0, 30, trig_n, done_n, auto_seen);
        rstn = 1'b0;
        i_arm = 1'b1;
        cen = 1'b1;
        tick();
        check("midrst_armed", int'(o_armed), 0);
        check("midrst_triggered", int'(o_triggered), 0);
        check("midrst_done", int'(o_done), 0);
        rstn = 1'b1;
        i_arm = 1'b0;
        cen = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        cen = 1'b0;
        check("midrst_idle_armed", int'(o_armed), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
